// File: rtl/memory_reader_pkg.sv
// Shared types and configuration checks for the memory reader and its FIFO.
package memory_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int READ_LATENCY_MIN = 1;
  localparam int READ_LATENCY_MAX = 4;

  // Depth must be a power of two and leave room for a full pipe plus one spare slot.
  function automatic bit fifo_depth_ok(input int depth, input int latency);
    return (depth > 0) && ((depth & (depth - 1)) == 0) && (depth >= latency + 2);
  endfunction

endpackage

// File: rtl/memory_reader_checker.sv
// Configuration and FIFO-occupancy properties for memory_reader.
module memory_reader_checker #(
  parameter int DEPTH  = 4,
  parameter bit CFG_OK = 1'b1
) (
  input logic                   clock_in,
  input logic                   reset_N,
  input logic                   push,
  input logic                   pop,
  input logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;

  a_cfg_legal: assert property (@(posedge clock_in) CFG_OK);

  a_no_overflow: assert property (@(posedge clock_in) disable iff (!reset_N)
    !(push && !pop && (count == CW'(DEPTH))));

  a_no_underflow: assert property (@(posedge clock_in) disable iff (!reset_N)
    !(pop && (count == CW'(0))));

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; head reads zero while empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clock_in,
  input  logic                   reset_N,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic                   not_empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_s;
  logic             push_ok_s;
  logic             pop_ok_s;

  // A push into a full FIFO is dropped unless a pop frees the slot the same cycle.
  assign pop_ok_s  = pop & not_empty;
  assign push_ok_s = push & ((count_r != CW'(DEPTH)) | pop_ok_s);

  // Occupancy next-value.
  always_comb begin
    count_s = count_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_s = count_r + CW'(1);
      2'b01:   count_s = count_r - CW'(1);
      default: count_s = count_r;
    endcase
  end

  // Storage write port.
  always_ff @(posedge clock_in) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clock_in or negedge reset_N) begin
    if (!reset_N) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_s;
    end
  end

  assign not_empty = (count_r != CW'(0));
  assign head_data = not_empty ? mem_r[rd_ptr_r] : {WIDTH{1'b0}};
  assign count     = count_r;

endmodule

// File: rtl/memory_reader.sv
// Sweeps an external synchronous memory from address 0 to END_ADDR and streams the words out.
module memory_reader
  import memory_reader_pkg::*;
#(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 8,
  parameter int END_ADDR     = 2**ADDR_WIDTH - 1,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clock_in,
  input  logic                  reset_N,
  input  logic                  start_in,
  input  logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  clock_out,
  output logic                  rd_en_out,
  output logic [ADDR_WIDTH-1:0] address_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic                  busy_out,
  output logic                  done_out
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = CW + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(END_ADDR);
  localparam bit CFG_OK = fifo_depth_ok(FIFO_DEPTH, READ_LATENCY) &&
                          (READ_LATENCY >= READ_LATENCY_MIN) &&
                          (READ_LATENCY <= READ_LATENCY_MAX);

  state_e                  state_r;
  state_e                  state_s;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [ADDR_WIDTH-1:0]   addr_s;
  logic [READ_LATENCY-1:0] pipe_r;
  logic [CW-1:0]           inflight_r;
  logic [CW-1:0]           inflight_s;
  logic [CW-1:0]           fifo_count_s;
  logic [CW-1:0]           fifo_count_next_s;
  logic [SW-1:0]           credit_sum_s;
  logic                    rd_en_r;
  logic                    rd_en_s;
  logic                    busy_r;
  logic                    done_r;
  logic                    issue_s;
  logic                    push_s;
  logic                    pop_s;
  logic                    not_empty_s;

  assign issue_s = rd_en_r;
  assign push_s  = pipe_r[READ_LATENCY-1];
  assign pop_s   = not_empty_s & ready_in;

  // Sweep sequencing: state and address counter next-values.
  always_comb begin
    state_s = state_r;
    addr_s  = addr_r;
    case (state_r)
      IDLE: begin
        if (start_in) begin
          state_s = READ;
          addr_s  = {ADDR_WIDTH{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      READ: begin
        if (issue_s && (addr_r == LAST_ADDR)) begin
          state_s = DRAIN;
        end else if (issue_s) begin
          addr_s = addr_r + ADDR_WIDTH'(1);
        end else begin
          state_s = READ;
        end
      end
      DRAIN: begin
        if ((inflight_r == CW'(0)) && (fifo_count_s == CW'(0))) begin
          state_s = DONE;
        end else begin
          state_s = DRAIN;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Credit: rd_en for the next cycle is judged on the counts that will be registered then.
  always_comb begin
    inflight_s        = inflight_r;
    fifo_count_next_s = fifo_count_s;
    case ({issue_s, push_s})
      2'b10:   inflight_s = inflight_r + CW'(1);
      2'b01:   inflight_s = inflight_r - CW'(1);
      default: inflight_s = inflight_r;
    endcase
    case ({push_s, pop_s})
      2'b10:   fifo_count_next_s = fifo_count_s + CW'(1);
      2'b01:   fifo_count_next_s = fifo_count_s - CW'(1);
      default: fifo_count_next_s = fifo_count_s;
    endcase
    credit_sum_s = SW'(inflight_s) + SW'(fifo_count_next_s);
    rd_en_s      = (state_s == READ) && (credit_sum_s < SW'(FIFO_DEPTH));
  end

  // Control registers, latency pipe and registered status outputs.
  always_ff @(posedge clock_in or negedge reset_N) begin
    if (!reset_N) begin
      state_r    <= IDLE;
      addr_r     <= {ADDR_WIDTH{1'b0}};
      pipe_r     <= {READ_LATENCY{1'b0}};
      inflight_r <= {CW{1'b0}};
      rd_en_r    <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      addr_r     <= addr_s;
      pipe_r     <= (pipe_r << 1'b1) | READ_LATENCY'(issue_s);
      inflight_r <= inflight_s;
      rd_en_r    <= rd_en_s;
      busy_r     <= (state_s == READ) || (state_s == DRAIN);
      done_r     <= (state_s == DONE);
    end
  end

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock_in  (clock_in),
    .reset_N   (reset_N),
    .push      (push_s),
    .push_data (mem_data_in),
    .pop       (pop_s),
    .head_data (data_out),
    .not_empty (not_empty_s),
    .count     (fifo_count_s)
  );

  memory_reader_checker #(
    .DEPTH  (FIFO_DEPTH),
    .CFG_OK (CFG_OK)
  ) u_checker (
    .clock_in (clock_in),
    .reset_N  (reset_N),
    .push     (push_s),
    .pop      (pop_s),
    .count    (fifo_count_s)
  );

  assign clock_out   = clock_in;
  assign rd_en_out   = rd_en_r;
  assign address_out = addr_r;
  assign valid_out   = not_empty_s;
  assign busy_out    = busy_r;
  assign done_out    = done_r;

endmodule
